// File: rtl/shift_pkg.sv
// Shared constants and types for the shift execute stage.
// Optional rotate functs are enabled by SHIFT_EXEC_ROTATE_EN.
package shift_pkg;

  localparam logic [5:0] FUNCT_SLL   = 6'b000000;
  localparam logic [5:0] FUNCT_ROTR  = 6'b000001;
  localparam logic [5:0] FUNCT_SRL   = 6'b000010;
  localparam logic [5:0] FUNCT_SRA   = 6'b000011;
  localparam logic [5:0] FUNCT_SLLV  = 6'b000100;
  localparam logic [5:0] FUNCT_ROTRV = 6'b000101;
  localparam logic [5:0] FUNCT_SRLV  = 6'b000110;
  localparam logic [5:0] FUNCT_SRAV  = 6'b000111;

  localparam logic [1:0] SHOP_SRL = 2'b00;
  localparam logic [1:0] SHOP_SRA = 2'b01;
  localparam logic [1:0] SHOP_SLL = 2'b10;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        illegal;
  } buf_entry_t;

endpackage

// File: rtl/shift_decode.sv
// Decodes R-type shift functs into shifter controls.
// Rotate functs are legal only when SHIFT_EXEC_ROTATE_EN is defined.
module shift_decode
  import shift_pkg::*;
(
  input  logic [5:0] funct,
  input  logic [4:0] shamt,
  input  logic [4:0] rs_amt,
  output logic [1:0] shiftop,
  output logic [4:0] shiftamt,
  output logic       is_rotate,
  output logic       illegal
);

  always_comb begin
    shiftop   = SHOP_SRL;
    shiftamt  = 5'd0;
    is_rotate = 1'b0;
    illegal   = 1'b0;
    unique case (funct)
      FUNCT_SLL:  begin shiftop = SHOP_SLL; shiftamt = shamt;  end
      FUNCT_SRL:  begin shiftop = SHOP_SRL; shiftamt = shamt;  end
      FUNCT_SRA:  begin shiftop = SHOP_SRA; shiftamt = shamt;  end
      FUNCT_SLLV: begin shiftop = SHOP_SLL; shiftamt = rs_amt; end
      FUNCT_SRLV: begin shiftop = SHOP_SRL; shiftamt = rs_amt; end
      FUNCT_SRAV: begin shiftop = SHOP_SRA; shiftamt = rs_amt; end
`ifdef SHIFT_EXEC_ROTATE_EN
      // Rotate = srl by n on the main shifter, OR'd with sll by 32-n on a second one.
      FUNCT_ROTR:  begin shiftop = SHOP_SRL; shiftamt = shamt;  is_rotate = 1'b1; end
      FUNCT_ROTRV: begin shiftop = SHOP_SRL; shiftamt = rs_amt; is_rotate = 1'b1; end
`endif
      default:    illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/shifter.sv
// Combinational barrel shifter: op 00 srl, 01 sra, 10 sll.
module shifter (
  input  logic [31:0] in,
  input  logic [1:0]  shiftop,
  input  logic [4:0]  shiftamt,
  output logic [31:0] result
);

  always_comb begin
    result = in;
    case (shiftop)
      2'b00:   result = in >> shiftamt;
      2'b01:   result = $signed(in) >>> shiftamt;
      2'b10:   result = in << shiftamt;
      default: result = in;
    endcase
  end

endmodule

// File: rtl/shift_exec_stage.sv
// Shift execute stage: decode + shifter feeding a 2-entry valid/ready output buffer.
// Define SHIFT_EXEC_ROTATE_EN to add rotr/rotrv.
module shift_exec_stage
  import shift_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned DW    = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [5:0]    in_funct,
  input  logic [4:0]    in_shamt,
  input  logic [DW-1:0] in_rs,
  input  logic [DW-1:0] in_rt,
  input  logic [4:0]    in_rd,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_result,
  output logic [4:0]    out_rd,
  output logic          out_illegal
);

  if (DEPTH != 2) begin : g_bad_depth
    $error("shift_exec_stage: DEPTH must be 2");
  end
  if (DW != 32) begin : g_bad_dw
    $error("shift_exec_stage: DW must be 32");
  end

  logic [1:0]  dec_op;
  logic [4:0]  dec_amt;
  logic        dec_rotate;
  logic        dec_illegal;
  logic [31:0] sh_out;
  logic [31:0] shift_res;

  shift_decode u_decode (
    .funct     (in_funct),
    .shamt     (in_shamt),
    .rs_amt    (in_rs[4:0]),
    .shiftop   (dec_op),
    .shiftamt  (dec_amt),
    .is_rotate (dec_rotate),
    .illegal   (dec_illegal)
  );

  shifter u_shifter (
    .in       (in_rt),
    .shiftop  (dec_op),
    .shiftamt (dec_amt),
    .result   (sh_out)
  );

`ifdef SHIFT_EXEC_ROTATE_EN
  logic [31:0] rot_left;

  // 32-n taken mod 32, so n=0 gives rt<<0 and the OR still yields rt.
  shifter u_rot_shifter (
    .in       (in_rt),
    .shiftop  (SHOP_SLL),
    .shiftamt (5'(5'd0 - dec_amt)),
    .result   (rot_left)
  );

  assign shift_res = dec_rotate ? (sh_out | rot_left) : sh_out;
`else
  assign shift_res = sh_out;
`endif

  logic unused_bits;
  assign unused_bits = ^{in_rs[DW-1:5], dec_rotate};

  buf_entry_t mem_q [2];
  buf_entry_t new_entry;
  logic       wr_ptr_q, rd_ptr_q;
  logic [1:0] count_q, count_d;
  logic       push, pop;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_comb begin
    new_entry         = '0;
    new_entry.result  = dec_illegal ? 32'd0 : shift_res;
    new_entry.rd      = in_rd;
    new_entry.illegal = dec_illegal;
  end

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (pop && !push) begin
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
    end else begin
      count_q <= count_d;
      if (flush) begin
        wr_ptr_q <= 1'b0;
        rd_ptr_q <= 1'b0;
      end else begin
        if (push) begin
          mem_q[wr_ptr_q] <= new_entry;
          wr_ptr_q        <= ~wr_ptr_q;
        end
        if (pop) rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  assign out_result  = mem_q[rd_ptr_q].result;
  assign out_rd      = mem_q[rd_ptr_q].rd;
  assign out_illegal = mem_q[rd_ptr_q].illegal;

endmodule

// File: tb/tb_shift_exec_stage.sv
// Directed self-checking bench for shift_exec_stage using immediate assertions.
module tb_shift_exec_stage;

  logic        clock = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [5:0]  in_funct;
  logic [4:0]  in_shamt, in_rd, out_rd;
  logic [31:0] in_rs, in_rt, out_result;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  shift_exec_stage u_dut (
    .clock       (clock),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_funct    (in_funct),
    .in_shamt    (in_shamt),
    .in_rs       (in_rs),
    .in_rt       (in_rt),
    .in_rd       (in_rd),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_rd      (out_rd),
    .out_illegal (out_illegal)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [5:0] f, input logic [4:0] sa, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [4:0] rd);
    in_valid = 1'b1;
    in_funct = f;
    in_shamt = sa;
    in_rs    = rs;
    in_rt    = rt;
    in_rd    = rd;
  endtask

  // Issue one instruction into an empty buffer, check the head, then let it drain.
  task automatic one(input string tag, input logic [5:0] f, input logic [4:0] sa,
                     input logic [31:0] rs, input logic [31:0] rt, input logic [4:0] rd,
                     input logic [31:0] exp_res, input logic exp_ill);
    out_ready = 1'b1;
    drive(f, sa, rs, rt, rd);
    step();
    in_valid = 1'b0;
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_result"}, out_result, exp_res);
    check({tag, "_rd"}, {27'd0, out_rd}, {27'd0, rd});
    check({tag, "_illegal"}, {31'd0, out_illegal}, {31'd0, exp_ill});
    step();
    check({tag, "_drained"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_funct = '0; in_shamt = '0; in_rs = '0; in_rt = '0; in_rd = '0;
    step();
    step();
    reset = 1'b0;
    step();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", out_result, 32'd0);
    check("rst_rd", {27'd0, out_rd}, 32'd0);
    check("rst_illegal", {31'd0, out_illegal}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    one("sll",  6'b000000, 5'd4,  32'h0, 32'h0000_0001, 5'd3, 32'h0000_0010, 1'b0);
    one("sra",  6'b000011, 5'd31, 32'h0, 32'h8000_0000, 5'd4, 32'hFFFF_FFFF, 1'b0);
    one("srl",  6'b000010, 5'd31, 32'h0, 32'h8000_0000, 5'd5, 32'h0000_0001, 1'b0);
    one("srlv", 6'b000110, 5'd0,  32'h0000_0025, 32'hF000_0000, 5'd6, 32'h0780_0000, 1'b0);
    one("srav", 6'b000111, 5'd0,  32'h0000_0025, 32'hF000_0000, 5'd6, 32'hFF80_0000, 1'b0);
    one("sllv", 6'b000100, 5'd9,  32'hFFFF_FFE4, 32'h0000_000F, 5'd8, 32'h0000_00F0, 1'b0);
    one("sll0", 6'b000000, 5'd0,  32'h0, 32'hDEAD_BEEF, 5'd9, 32'hDEAD_BEEF, 1'b0);
    one("sra0", 6'b000011, 5'd0,  32'h0, 32'h8000_0001, 5'd9, 32'h8000_0001, 1'b0);
    one("ill20", 6'b100000, 5'd3, 32'h0, 32'h1234_5678, 5'd7, 32'h0000_0000, 1'b1);
`ifdef SHIFT_EXEC_ROTATE_EN
    one("rotr",  6'b000001, 5'd1, 32'h0, 32'h0000_0001, 5'd10, 32'h8000_0000, 1'b0);
    one("rotrv", 6'b000101, 5'd0, 32'h0000_0004, 32'h0000_00F1, 5'd11, 32'h1000_000F, 1'b0);
    one("rotr0", 6'b000001, 5'd0, 32'h0, 32'hCAFE_F00D, 5'd12, 32'hCAFE_F00D, 1'b0);
`else
    one("rotr_ill",  6'b000001, 5'd1, 32'h0, 32'h0000_0001, 5'd10, 32'h0, 1'b1);
    one("rotrv_ill", 6'b000101, 5'd0, 32'h4, 32'h0000_00F1, 5'd11, 32'h0, 1'b1);
`endif

    // Backpressure: A, B accepted, C held until space frees up.
    out_ready = 1'b0;
    drive(6'b000000, 5'd1, 32'h0, 32'h1, 5'd1);
    step();
    check("bp_a_ready", {31'd0, in_ready}, 32'd1);
    check("bp_a_head", out_result, 32'h2);
    drive(6'b000000, 5'd2, 32'h0, 32'h1, 5'd2);
    step();
    check("bp_full_ready", {31'd0, in_ready}, 32'd0);
    check("bp_full_head", out_result, 32'h2);
    drive(6'b000000, 5'd3, 32'h0, 32'h1, 5'd3);
    step();
    check("bp_held_ready", {31'd0, in_ready}, 32'd0);
    check("bp_held_head_rd", {27'd0, out_rd}, 32'd1);
    check("bp_held_head", out_result, 32'h2);
    out_ready = 1'b1;
    step();
    check("bp_b_head", out_result, 32'h4);
    check("bp_b_rd", {27'd0, out_rd}, 32'd2);
    check("bp_b_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    check("bp_c_valid", {31'd0, out_valid}, 32'd1);
    check("bp_c_head", out_result, 32'h8);
    check("bp_c_rd", {27'd0, out_rd}, 32'd3);
    step();
    check("bp_empty", {31'd0, out_valid}, 32'd0);

    // Flush with a full buffer and a pending input.
    out_ready = 1'b0;
    drive(6'b000000, 5'd4, 32'h0, 32'h1, 5'd10);
    step();
    drive(6'b000000, 5'd5, 32'h0, 32'h1, 5'd11);
    step();
    check("fl_full", {31'd0, in_ready}, 32'd0);
    drive(6'b000000, 5'd6, 32'h0, 32'h1, 5'd12);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl_out_valid", {31'd0, out_valid}, 32'd0);
    check("fl_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    step();
    check("fl_stays_empty", {31'd0, out_valid}, 32'd0);

    // Flush beats a push that would otherwise be accepted.
    out_ready = 1'b0;
    drive(6'b000000, 5'd7, 32'h0, 32'h1, 5'd13);
    step();
    drive(6'b000000, 5'd8, 32'h0, 32'h1, 5'd14);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl1_out_valid", {31'd0, out_valid}, 32'd0);
    step();
    check("fl1_stays_empty", {31'd0, out_valid}, 32'd0);

    // Reset mid-stream zeroes everything.
    drive(6'b000000, 5'd1, 32'h0, 32'h3, 5'd15);
    step();
    drive(6'b000011, 5'd1, 32'h0, 32'h8000_0000, 5'd16);
    step();
    reset = 1'b1;
    drive(6'b000000, 5'd2, 32'h0, 32'h3, 5'd17);
    step();
    check("mr_out_valid", {31'd0, out_valid}, 32'd0);
    check("mr_result", out_result, 32'd0);
    check("mr_rd", {27'd0, out_rd}, 32'd0);
    check("mr_illegal", {31'd0, out_illegal}, 32'd0);
    step();
    check("mr_ignored", {31'd0, out_valid}, 32'd0);
    reset = 1'b0;
    in_valid = 1'b0;
    step();
    check("mr_in_ready", {31'd0, in_ready}, 32'd1);
    check("mr_empty", {31'd0, out_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
